// File: rtl/phase_dc_scheduler_pkg.sv
// Shared types for the phase DC-offset scheduler slice.
// Channel tags, FSM encodings and the engine tag bundle.
`timescale 1ns/1ps
package phase_dc_scheduler_pkg;

  localparam int DW_DEFAULT = 14;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_A = 3'd1,
    S_ISSUE_B = 3'd2,
    S_ISSUE_C = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] ch;
  } tag_t;

endpackage

// File: rtl/phase_dc_scheduler_if.sv
// Bus bundle of the scheduler: ADC triplet in, engine port, triplet out.
// slave = scheduler side, master = surrounding datapath/engine side.
`timescale 1ns/1ps
interface phase_dc_scheduler_if
  import phase_dc_scheduler_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          sample_valid;
  logic [DW-1:0] va_in;
  logic [DW-1:0] vb_in;
  logic [DW-1:0] vc_in;
  logic          clear_ovr;

  logic          eng_valid;
  logic [1:0]    eng_ch;
  logic [DW-1:0] eng_vin;
  logic [DW-1:0] eng_vout;

  logic [DW-1:0] va_out;
  logic [DW-1:0] vb_out;
  logic [DW-1:0] vc_out;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  modport slave (
    input  sample_valid, va_in, vb_in, vc_in,
    input  clear_ovr, eng_vout,
    output eng_valid, eng_ch, eng_vin,
    output va_out, vb_out, vc_out,
    output out_valid, busy, overrun
  );

  modport master (
    output sample_valid, va_in, vb_in, vc_in,
    output clear_ovr, eng_vout,
    input  eng_valid, eng_ch, eng_vin,
    input  va_out, vb_out, vc_out,
    input  out_valid, busy, overrun
  );

endinterface

// File: rtl/phase_dc_scheduler_tag_delay.sv
// tag_delay_line: async-reset shift register, DEPTH stages of W bits.
// Ports: clk, rst, din (stage 0 input), dout (last stage output).
`timescale 1ns/1ps
module tag_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/phase_dc_scheduler.sv
// Time-multiplexes one DC-offset engine over phases A/B/C.
// Ports: clk, rst (async high), bus (slave modport of phase_dc_scheduler_if).
`timescale 1ns/1ps
module phase_dc_scheduler
  import phase_dc_scheduler_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int ENG_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  phase_dc_scheduler_if.slave  bus
);

  state_t        state;
  state_t        nxt;

  logic [DW-1:0] act_a;
  logic [DW-1:0] act_b;
  logic [DW-1:0] act_c;
  logic [DW-1:0] pnd_a;
  logic [DW-1:0] pnd_b;
  logic [DW-1:0] pnd_c;
  logic          pnd_full;

  logic [DW-1:0] res_a;
  logic [DW-1:0] res_b;
  logic [DW-1:0] va_q;
  logic [DW-1:0] vb_q;
  logic [DW-1:0] vc_q;
  logic          ovr_q;

  logic          eng_valid;
  logic [1:0]    eng_ch;
  logic [DW-1:0] eng_vin;
  logic          out_valid;
  logic          busy;
  logic          load_out;
  logic          drop;

  tag_t          tag_in;
  tag_t          tag_out;

  assign tag_in = '{valid: eng_valid, ch: eng_ch};

  tag_delay_line #(
    .DEPTH (ENG_LAT),
    .W     (3)
  ) u_tags (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    eng_valid = 1'b0;
    eng_ch    = CH_A;
    eng_vin   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.sample_valid) nxt = S_ISSUE_A;
      end
      S_ISSUE_A: begin
        eng_valid = 1'b1;
        eng_ch    = CH_A;
        eng_vin   = act_a;
        busy      = 1'b1;
        nxt       = S_ISSUE_B;
      end
      S_ISSUE_B: begin
        eng_valid = 1'b1;
        eng_ch    = CH_B;
        eng_vin   = act_b;
        busy      = 1'b1;
        nxt       = S_ISSUE_C;
      end
      S_ISSUE_C: begin
        eng_valid = 1'b1;
        eng_ch    = CH_C;
        eng_vin   = act_c;
        busy      = 1'b1;
        nxt       = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // C is issued last, so its return means A and B are in.
        if (tag_out.valid && tag_out.ch == CH_C) begin
          load_out = 1'b1;
          nxt      = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (pnd_full || bus.sample_valid) nxt = S_ISSUE_A;
        else                              nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // DONE never drops: the pending slot is freed that same cycle.
  assign drop = bus.sample_valid && busy && pnd_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a    <= '0;
      act_b    <= '0;
      act_c    <= '0;
      pnd_a    <= '0;
      pnd_b    <= '0;
      pnd_c    <= '0;
      pnd_full <= 1'b0;
    end else if (state == S_IDLE) begin
      if (bus.sample_valid) begin
        act_a <= bus.va_in;
        act_b <= bus.vb_in;
        act_c <= bus.vc_in;
      end
    end else if (state == S_DONE) begin
      if (pnd_full) begin
        act_a <= pnd_a;
        act_b <= pnd_b;
        act_c <= pnd_c;
        if (bus.sample_valid) begin
          pnd_a <= bus.va_in;
          pnd_b <= bus.vb_in;
          pnd_c <= bus.vc_in;
        end else begin
          pnd_full <= 1'b0;
        end
      end else if (bus.sample_valid) begin
        act_a <= bus.va_in;
        act_b <= bus.vb_in;
        act_c <= bus.vc_in;
      end
    end else if (bus.sample_valid && !pnd_full) begin
      pnd_a    <= bus.va_in;
      pnd_b    <= bus.vb_in;
      pnd_c    <= bus.vc_in;
      pnd_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_a <= '0;
      res_b <= '0;
    end else if (tag_out.valid) begin
      case (tag_out.ch)
        CH_A:    res_a <= bus.eng_vout;
        CH_B:    res_b <= bus.eng_vout;
        default: ;
      endcase
    end
  end

  // C goes straight to the output so the triplet lands in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q <= '0;
      vb_q <= '0;
      vc_q <= '0;
    end else if (load_out) begin
      va_q <= res_a;
      vb_q <= res_b;
      vc_q <= bus.eng_vout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ovr_q <= 1'b0;
    else if (drop)          ovr_q <= 1'b1;
    else if (bus.clear_ovr) ovr_q <= 1'b0;
  end

  assign bus.eng_valid = eng_valid;
  assign bus.eng_ch    = eng_ch;
  assign bus.eng_vin   = eng_vin;
  assign bus.va_out    = va_q;
  assign bus.vb_out    = vb_q;
  assign bus.vc_out    = vc_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.overrun   = ovr_q;

endmodule
